// File: rtl/pfb_synth_real_lane.sv
`default_nettype none
// ============================================================================
//  Module   : pfb_synth_real_lane
//  Purpose  : Synthesis-side polyphase filter lane (weighted overlap-add).
//             For sample p of frame m:
//               y_m[p] = sum_k g[p + k*PFB_SIZE] * x_{m-k}[p],  k = 0..TAPS-1
//             Valid-qualified: index, history and fill advance only on din_valid.
//  Ports    : clk        - clock, rising edge
//             rst_n      - asynchronous active-low reset
//             din        - signed IFFT sample (DIN_WIDTH, point DIN_POINT)
//             din_valid  - din qualifier
//             sync_in    - frame start, honoured only together with din_valid
//             dout       - signed synthesized sample (DOUT_WIDTH, point DOUT_POINT)
//             dout_valid - din_valid delayed by the pipeline latency
//             sync_out   - (sync_in & din_valid) delayed by the pipeline latency
//             ovf_flag   - sticky saturation flag, cleared by reset or a sync
//  Coeffs   : COEFF_INIT is the flattened coefficient table, entry
//             k*PFB_SIZE + p at bits [(k*PFB_SIZE+p)*COEFF_WIDTH +: COEFF_WIDTH].
//  Revision : 1.0 - initial release
// ============================================================================
module pfb_synth_real_lane #(
    parameter int DIN_WIDTH   = 16,
    parameter int DIN_POINT   = 15,
    parameter int TAPS        = 4,
    parameter int PFB_SIZE    = 64,
    parameter int COEFF_WIDTH = 18,
    parameter int COEFF_POINT = 17,
    parameter int DOUT_WIDTH  = 18,
    parameter int DOUT_POINT  = 17,
    parameter logic [TAPS*PFB_SIZE*COEFF_WIDTH-1:0] COEFF_INIT =
        {(TAPS*PFB_SIZE){COEFF_WIDTH'(1 << (COEFF_POINT - 1))}}
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic signed [DIN_WIDTH-1:0]  din,
    input  logic                         din_valid,
    input  logic                         sync_in,
    output logic signed [DOUT_WIDTH-1:0] dout,
    output logic                         dout_valid,
    output logic                         sync_out,
    output logic                         ovf_flag
);

    localparam int c_p_w    = $clog2(PFB_SIZE);
    localparam int c_lv     = $clog2(TAPS);          // adder-tree levels, also fill width
    localparam int c_n      = 1 << c_lv;             // tree leaves (TAPS padded to 2^c_lv)
    localparam int c_prod_w = DIN_WIDTH + COEFF_WIDTH;
    localparam int c_sum_w  = c_prod_w + c_lv;
    localparam int c_lat    = 3 + c_lv;              // read, multiply, tree, resize
    localparam int c_shift  = DIN_POINT + COEFF_POINT - DOUT_POINT;

    localparam logic [DOUT_WIDTH-1:0] c_max = {1'b0, {(DOUT_WIDTH-1){1'b1}}};
    localparam logic [DOUT_WIDTH-1:0] c_min = {1'b1, {(DOUT_WIDTH-1){1'b0}}};

    // ------------------------------------------------------------------------
    // Frame position and fill tracking
    // ------------------------------------------------------------------------
    logic              w_start;
    logic [c_p_w-1:0]  r_p;
    logic [c_p_w-1:0]  w_p;
    logic [c_lv-1:0]   r_fill;
    logic [c_lv-1:0]   w_fill;

    // A valid sync makes the current sample p=0 of a fresh frame with nothing
    // older behind it, so both index and fill restart combinationally.
    always_comb begin
        w_start = din_valid & sync_in;
        w_p     = w_start ? '0 : r_p;
        w_fill  = w_start ? '0 : r_fill;
    end

    // ------------------------------------------------------------------------
    // History RAMs, coefficient ROM read, products and adder tree
    // ------------------------------------------------------------------------
    logic signed [DIN_WIDTH-1:0]   r_hist [TAPS-1][PFB_SIZE];
    logic signed [DIN_WIDTH-1:0]   r_x    [TAPS];
    logic signed [COEFF_WIDTH-1:0] r_c    [TAPS];
    logic signed [c_prod_w-1:0]    w_prod [TAPS];
    logic signed [c_sum_w-1:0]     r_tree [c_lv+1][c_n];

    always_comb begin
        for (int k = 0; k < TAPS; k++) begin
            w_prod[k] = c_prod_w'(r_x[k]) * c_prod_w'(r_c[k]);
        end
    end

    // Datapath registers carry no reset: qualification travels in the valid
    // pipeline and stale history is masked by the fill count.
    always_ff @(posedge clk) begin
        r_x[0] <= din;
        for (int k = 1; k < TAPS; k++) begin
            r_x[k] <= (c_lv'(k) <= w_fill) ? r_hist[k-1][w_p] : '0;
        end
        for (int k = 0; k < TAPS; k++) begin
            r_c[k] <= COEFF_INIT[(k * PFB_SIZE + int'(w_p)) * COEFF_WIDTH +: COEFF_WIDTH];
        end

        // Shift the frame history at this index after the read above.
        if (din_valid) begin
            r_hist[0][w_p] <= din;
            for (int k = 1; k < TAPS - 1; k++) begin
                r_hist[k][w_p] <= r_hist[k-1][w_p];
            end
        end

        for (int k = 0; k < TAPS; k++) begin
            r_tree[0][k] <= c_sum_w'(w_prod[k]);
        end
        for (int k = TAPS; k < c_n; k++) begin
            r_tree[0][k] <= '0;
        end
        for (int l = 0; l < c_lv; l++) begin
            for (int i = 0; i < c_n / 2; i++) begin
                r_tree[l+1][i] <= r_tree[l][2*i] + r_tree[l][2*i+1];
            end
            for (int i = c_n / 2; i < c_n; i++) begin
                r_tree[l+1][i] <= '0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Resize: floor-shift to the output point, then saturate
    // ------------------------------------------------------------------------
    logic signed [c_sum_w-1:0]       w_shifted;
    logic [c_sum_w-DOUT_WIDTH:0]     w_hi;
    logic                            w_ovf;
    logic [DOUT_WIDTH-1:0]           w_res;

    always_comb begin
        w_shifted = r_tree[c_lv][0] >>> c_shift;
        // In range only when every bit above the output sign bit matches it.
        w_hi      = w_shifted[c_sum_w-1:DOUT_WIDTH-1];
        w_ovf     = ~((&w_hi) | ~(|w_hi));
        w_res     = w_shifted[DOUT_WIDTH-1:0];
        if (w_ovf) begin
            w_res = w_shifted[c_sum_w-1] ? c_min : c_max;
        end
    end

    // ------------------------------------------------------------------------
    // Control state and registered outputs
    // ------------------------------------------------------------------------
    logic [c_lat-1:0]      r_vpipe;
    logic [c_lat-1:0]      r_spipe;
    logic [DOUT_WIDTH-1:0] r_dout;
    logic                  r_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p     <= '0;
            r_fill  <= '0;
            r_vpipe <= '0;
            r_spipe <= '0;
            r_dout  <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (din_valid) begin
                r_p <= w_p + c_p_w'(1);
                if (w_p == c_p_w'(PFB_SIZE - 1) && w_fill != c_lv'(TAPS - 1)) begin
                    r_fill <= w_fill + c_lv'(1);
                end else begin
                    r_fill <= w_fill;
                end
            end
            r_vpipe <= {r_vpipe[c_lat-2:0], din_valid};
            r_spipe <= {r_spipe[c_lat-2:0], w_start};
            // The sticky flag clears as the sync sample leaves, so it always
            // describes the output stream since the last frame restart.
            if (r_vpipe[c_lat-2]) begin
                r_dout <= w_res;
                r_ovf  <= (r_ovf & ~r_spipe[c_lat-2]) | w_ovf;
            end
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_vpipe[c_lat-1];
    assign sync_out   = r_spipe[c_lat-1];
    assign ovf_flag   = r_ovf;

endmodule
`default_nettype wire
